voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice-slot allocator.
// Picks a voice for each note-on (retrigger, then free, then steal the oldest
// releasing voice, then the oldest held voice) and emits per-voice
// start / release / hard-stop pulses.
// Optional feature: define SUSTAIN_PEDAL_EN to add the sustain input and the
// SUSTAINED voice state.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_WIDTH = 7,
  parameter int VEL_WIDTH  = 7
) (
  input  logic                             clock_50_000_000,
  input  logic                             reset,
  input  logic                             note_valid,
  input  logic                             note_status,
  input  logic [NOTE_WIDTH-1:0]            note_number,
  input  logic [VEL_WIDTH-1:0]             note_velocity,
  output logic                             note_ready,
  input  logic                             all_notes_off,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                             sustain,
`endif
  input  logic [NUM_VOICES-1:0]            envelope_end,
  output logic [NUM_VOICES-1:0]            voice_on,
  output logic [NUM_VOICES-1:0]            voice_off,
  output logic [NUM_VOICES-1:0]            voice_kill,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note,
  output logic [NUM_VOICES*VEL_WIDTH-1:0]  voice_velocity,
  output logic [NUM_VOICES-1:0]            voice_active
);

  localparam int IW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    V_FREE = 2'd0,
    V_HELD = 2'd1,
    V_SUST = 2'd2,
    V_REL  = 2'd3
  } vstate_t;

  typedef enum logic {
    C_IDLE  = 1'b0,
    C_STEAL = 1'b1
  } cstate_t;

  // Per-voice state
  vstate_t               r_vstate [NUM_VOICES];
  vstate_t               w_vstate_next [NUM_VOICES];
  logic [IW-1:0]         r_age [NUM_VOICES];
  logic [IW-1:0]         w_age_next [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] r_note [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] w_note_next [NUM_VOICES];
  logic [VEL_WIDTH-1:0]  r_vel [NUM_VOICES];
  logic [VEL_WIDTH-1:0]  w_vel_next [NUM_VOICES];

  // Controller state and the pending steal target
  cstate_t               r_ctrl, w_ctrl_next;
  logic [IW-1:0]         r_steal_idx, w_steal_idx_next;
  logic [NOTE_WIDTH-1:0] r_steal_note, w_steal_note_next;
  logic [VEL_WIDTH-1:0]  r_steal_vel, w_steal_vel_next;
  logic                  r_anoff_pend, w_anoff_pend_next;

  // Registered outputs
  logic [NUM_VOICES-1:0] r_on, r_off, r_kill, r_active;
  logic [NUM_VOICES-1:0] w_on_next, w_off_next, w_kill_next, w_active_next;

  // Candidate selection results
  logic                  w_match_hit, w_free_hit, w_rel_hit, w_off_hit;
  logic [IW-1:0]         w_match_idx, w_free_idx, w_rel_idx, w_hs_idx, w_off_idx;
  logic [IW-1:0]         w_victim;

  // Event decode and allocation request
  logic                  w_accept, w_is_on, w_sus_hold, w_sus_fall;
  logic                  w_alloc;
  logic [IW-1:0]         w_alloc_idx;
  logic [NOTE_WIDTH-1:0] w_alloc_note;
  logic [VEL_WIDTH-1:0]  w_alloc_vel;

`ifdef SUSTAIN_PEDAL_EN
  logic r_sus_q;

  // Remember the previous pedal level so a release of the pedal can be seen.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      r_sus_q <= 1'b0;
    end else begin
      r_sus_q <= sustain;
    end
  end

  assign w_sus_hold = sustain;
  assign w_sus_fall = r_sus_q & ~sustain;
`else
  assign w_sus_hold = 1'b0;
  assign w_sus_fall = 1'b0;
`endif

  // A pending all-notes-off also holds off new events so it is applied first.
  assign note_ready = (r_ctrl == C_IDLE) & ~all_notes_off & ~r_anoff_pend;
  assign w_accept   = note_valid & note_ready;
  assign w_is_on    = note_status & (note_velocity != {VEL_WIDTH{1'b0}});
  assign w_victim   = w_rel_hit ? w_rel_idx : w_hs_idx;

  // Scan the voices for retrigger, free, oldest-releasing, oldest-held and note-off targets.
  always_comb begin
    logic          l_hs_hit;
    logic [IW-1:0] l_rel_age;
    logic [IW-1:0] l_hs_age;
    logic          l_c;
    w_match_hit = 1'b0;
    w_match_idx = '0;
    w_free_hit  = 1'b0;
    w_free_idx  = '0;
    w_rel_hit   = 1'b0;
    w_rel_idx   = '0;
    w_hs_idx    = '0;
    w_off_hit   = 1'b0;
    w_off_idx   = '0;
    l_hs_hit    = 1'b0;
    l_rel_age   = '0;
    l_hs_age    = '0;
    l_c         = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      // lowest-index sounding voice already playing this note
      l_c         = ~w_match_hit & (r_vstate[i] != V_FREE) & (r_note[i] == note_number);
      w_match_idx = l_c ? IW'(i) : w_match_idx;
      w_match_hit = w_match_hit | l_c;
      // lowest-index free voice
      l_c         = ~w_free_hit & (r_vstate[i] == V_FREE);
      w_free_idx  = l_c ? IW'(i) : w_free_idx;
      w_free_hit  = w_free_hit | l_c;
      // oldest releasing voice (ages are unique, so no ties)
      l_c         = (r_vstate[i] == V_REL) & (~w_rel_hit | (r_age[i] > l_rel_age));
      w_rel_idx   = l_c ? IW'(i) : w_rel_idx;
      l_rel_age   = l_c ? r_age[i] : l_rel_age;
      w_rel_hit   = w_rel_hit | l_c;
      // oldest held or sustained voice
      l_c         = ((r_vstate[i] == V_HELD) | (r_vstate[i] == V_SUST)) &
                    (~l_hs_hit | (r_age[i] > l_hs_age));
      w_hs_idx    = l_c ? IW'(i) : w_hs_idx;
      l_hs_age    = l_c ? r_age[i] : l_hs_age;
      l_hs_hit    = l_hs_hit | l_c;
      // note-off only ever targets a held voice
      l_c         = ~w_off_hit & (r_vstate[i] == V_HELD) & (r_note[i] == note_number);
      w_off_idx   = l_c ? IW'(i) : w_off_idx;
      w_off_hit   = w_off_hit | l_c;
    end
  end

  // Controller next state, per-voice transitions, ages and output pulses.
  always_comb begin
    w_vstate_next     = r_vstate;
    w_age_next        = r_age;
    w_note_next       = r_note;
    w_vel_next        = r_vel;
    w_ctrl_next       = r_ctrl;
    w_steal_idx_next  = r_steal_idx;
    w_steal_note_next = r_steal_note;
    w_steal_vel_next  = r_steal_vel;
    w_anoff_pend_next = r_anoff_pend;
    w_on_next         = '0;
    w_off_next        = '0;
    w_kill_next       = '0;
    w_active_next     = '0;
    w_alloc           = 1'b0;
    w_alloc_idx       = '0;
    w_alloc_note      = note_number;
    w_alloc_vel       = note_velocity;

    // pedal release: every sustained voice starts its release together
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_sus_fall && (r_vstate[i] == V_SUST)) begin
        w_vstate_next[i] = V_REL;
        w_off_next[i]    = 1'b1;
      end else begin
        w_vstate_next[i] = w_vstate_next[i];
      end
    end

    case (r_ctrl)
      C_IDLE: begin
        if (all_notes_off || r_anoff_pend) begin
          w_anoff_pend_next = 1'b0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if ((r_vstate[i] == V_HELD) || (r_vstate[i] == V_SUST)) begin
              w_vstate_next[i] = V_REL;
              w_off_next[i]    = 1'b1;
            end else begin
              w_vstate_next[i] = w_vstate_next[i];
            end
          end
        end else if (w_accept && w_is_on) begin
          if (w_match_hit) begin
            w_alloc     = 1'b1;
            w_alloc_idx = w_match_idx;
          end else if (w_free_hit) begin
            w_alloc     = 1'b1;
            w_alloc_idx = w_free_idx;
          end else begin
            // steal: hard-stop now, hand the voice the new note next cycle
            w_kill_next[w_victim] = 1'b1;
            w_ctrl_next           = C_STEAL;
            w_steal_idx_next      = w_victim;
            w_steal_note_next     = note_number;
            w_steal_vel_next      = note_velocity;
          end
        end else if (w_accept && w_off_hit) begin
          if (w_sus_hold) begin
            w_vstate_next[w_off_idx] = V_SUST;
          end else begin
            w_vstate_next[w_off_idx] = V_REL;
            w_off_next[w_off_idx]    = 1'b1;
          end
        end else begin
          w_ctrl_next = C_IDLE;
        end
      end
      C_STEAL: begin
        w_alloc           = 1'b1;
        w_alloc_idx       = r_steal_idx;
        w_alloc_note      = r_steal_note;
        w_alloc_vel       = r_steal_vel;
        w_ctrl_next       = C_IDLE;
        w_anoff_pend_next = r_anoff_pend | all_notes_off;
      end
      default: begin
        w_ctrl_next = C_IDLE;
      end
    endcase

    // finished envelopes free their voice unless that voice is being reallocated
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (envelope_end[i] && (r_vstate[i] == V_REL) &&
          !(w_alloc && (w_alloc_idx == IW'(i)))) begin
        w_vstate_next[i] = V_FREE;
      end else begin
        w_vstate_next[i] = w_vstate_next[i];
      end
    end

    // allocation: newest voice gets age 0, younger voices age by one
    if (w_alloc) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        w_age_next[i] = (r_age[i] < r_age[w_alloc_idx]) ? (r_age[i] + IW'(1)) : r_age[i];
      end
      w_age_next[w_alloc_idx]    = '0;
      w_vstate_next[w_alloc_idx] = V_HELD;
      w_note_next[w_alloc_idx]   = w_alloc_note;
      w_vel_next[w_alloc_idx]    = w_alloc_vel;
      w_on_next[w_alloc_idx]     = 1'b1;
      w_off_next[w_alloc_idx]    = 1'b0;
    end else begin
      w_age_next = w_age_next;
    end

    for (int i = 0; i < NUM_VOICES; i++) begin
      w_active_next[i] = (w_vstate_next[i] != V_FREE);
    end
  end

  // State and output registers; reset aborts any steal in progress.
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_vstate[i] <= V_FREE;
        r_age[i]    <= IW'(i);
        r_note[i]   <= '0;
        r_vel[i]    <= '0;
      end
      r_ctrl       <= C_IDLE;
      r_steal_idx  <= '0;
      r_steal_note <= '0;
      r_steal_vel  <= '0;
      r_anoff_pend <= 1'b0;
      r_on         <= '0;
      r_off        <= '0;
      r_kill       <= '0;
      r_active     <= '0;
    end else begin
      r_vstate     <= w_vstate_next;
      r_age        <= w_age_next;
      r_note       <= w_note_next;
      r_vel        <= w_vel_next;
      r_ctrl       <= w_ctrl_next;
      r_steal_idx  <= w_steal_idx_next;
      r_steal_note <= w_steal_note_next;
      r_steal_vel  <= w_steal_vel_next;
      r_anoff_pend <= w_anoff_pend_next;
      r_on         <= w_on_next;
      r_off        <= w_off_next;
      r_kill       <= w_kill_next;
      r_active     <= w_active_next;
    end
  end

  assign voice_on     = r_on;
  assign voice_off    = r_off;
  assign voice_kill   = r_kill;
  assign voice_active = r_active;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_flat
    assign voice_note[g*NOTE_WIDTH +: NOTE_WIDTH]   = r_note[g];
    assign voice_velocity[g*VEL_WIDTH +: VEL_WIDTH] = r_vel[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed, table-driven bench for voice_allocator (4 voices, 7-bit note/velocity).
// Define SUSTAIN_PEDAL_EN for both files to exercise the sustain pedal sequence.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int NW = 7;
  localparam int VW = 7;

  logic             clk = 1'b0;
  logic             reset;
  logic             note_valid;
  logic             note_status;
  logic [NW-1:0]    note_number;
  logic [VW-1:0]    note_velocity;
  logic             note_ready;
  logic             all_notes_off;
  logic [NV-1:0]    envelope_end;
  logic [NV-1:0]    voice_on;
  logic [NV-1:0]    voice_off;
  logic [NV-1:0]    voice_kill;
  logic [NV*NW-1:0] voice_note;
  logic [NV*VW-1:0] voice_velocity;
  logic [NV-1:0]    voice_active;
`ifdef SUSTAIN_PEDAL_EN
  logic             sustain;
`endif

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .VEL_WIDTH(VW)) dut (
    .clock_50_000_000 (clk),
    .reset            (reset),
    .note_valid       (note_valid),
    .note_status      (note_status),
    .note_number      (note_number),
    .note_velocity    (note_velocity),
    .note_ready       (note_ready),
    .all_notes_off    (all_notes_off),
`ifdef SUSTAIN_PEDAL_EN
    .sustain          (sustain),
`endif
    .envelope_end     (envelope_end),
    .voice_on         (voice_on),
    .voice_off        (voice_off),
    .voice_kill       (voice_kill),
    .voice_note       (voice_note),
    .voice_velocity   (voice_velocity),
    .voice_active     (voice_active)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus plus the expected response after the edge.
  typedef struct {
    logic          rst;
    logic          vld;
    logic          st;
    logic [NW-1:0] nt;
    logic [VW-1:0] vl;
    logic          ao;
    logic [NV-1:0] env;
    logic          rdy;
    logic [NV-1:0] on;
    logic [NV-1:0] off;
    logic [NV-1:0] kill;
    logic [NV-1:0] act;
    int            cv;
    logic [NW-1:0] en;
    logic [VW-1:0] ev;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int vld, int st, int nt, int vl, int ao, int env,
                              int rdy, int on, int off, int kill, int act,
                              int cv, int en, int ev);
    vec_t v;
    v.rst  = 1'(rst);
    v.vld  = 1'(vld);
    v.st   = 1'(st);
    v.nt   = NW'(nt);
    v.vl   = VW'(vl);
    v.ao   = 1'(ao);
    v.env  = NV'(env);
    v.rdy  = 1'(rdy);
    v.on   = NV'(on);
    v.off  = NV'(off);
    v.kill = NV'(kill);
    v.act  = NV'(act);
    v.cv   = cv;
    v.en   = NW'(en);
    v.ev   = VW'(ev);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    reset         = v.rst;
    note_valid    = v.vld;
    note_status   = v.st;
    note_number   = v.nt;
    note_velocity = v.vl;
    all_notes_off = v.ao;
    envelope_end  = v.env;
    n_vec++;
    #1;
    if (!v.rst) begin
      chk({tag, " note_ready"}, 64'(note_ready), 64'(v.rdy));
    end
    @(posedge clk);
    #1;
    chk({tag, " voice_on"},     64'(voice_on),     64'(v.on));
    chk({tag, " voice_off"},    64'(voice_off),    64'(v.off));
    chk({tag, " voice_kill"},   64'(voice_kill),   64'(v.kill));
    chk({tag, " voice_active"}, 64'(voice_active), 64'(v.act));
    if (v.cv >= 0) begin
      chk({tag, " voice_note"},     64'(voice_note[v.cv*NW +: NW]),     64'(v.en));
      chk({tag, " voice_velocity"}, 64'(voice_velocity[v.cv*VW +: VW]), 64'(v.ev));
    end
  endtask

  initial begin
    logic [NV*NW-1:0] exp_notes;
    logic [NV*VW-1:0] exp_vels;
`ifdef SUSTAIN_PEDAL_EN
    sustain = 1'b0;
`endif
    //              rst vld st  nt  vl ao env      rdy on      off     kill    act     cv en  ev
    // reset, first note, then fill all four voices
    tbl.push_back(mk(1, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0000, 0,  0,  0));
    tbl.push_back(mk(0, 1, 1, 60,100, 0, 'b0000, 1, 'b0001, 'b0000, 'b0000, 'b0001, 0, 60,100));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0001,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 62,100, 0, 'b0000, 1, 'b0010, 'b0000, 'b0000, 'b0011, 1, 62,100));
    tbl.push_back(mk(0, 1, 1, 64,100, 0, 'b0000, 1, 'b0100, 'b0000, 'b0000, 'b0111, 2, 64,100));
    tbl.push_back(mk(0, 1, 1, 65,100, 0, 'b0000, 1, 'b1000, 'b0000, 'b0000, 'b1111, 3, 65,100));
    // fifth note steals the oldest held voice 0 over two cycles
    tbl.push_back(mk(0, 1, 1, 67, 90, 0, 'b0000, 1, 'b0000, 'b0000, 'b0001, 'b1111, 0, 60,100));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0000, 0, 'b0001, 'b0000, 'b0000, 'b1111, 0, 67, 90));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b1111,-1,  0,  0));
    // ages now 0,3,2,1: release voice 2, then a steal must take it, not older held voice 1
    tbl.push_back(mk(0, 1, 0, 64,  0, 0, 'b0000, 1, 'b0000, 'b0100, 'b0000, 'b1111,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 69, 80, 0, 'b0000, 1, 'b0000, 'b0000, 'b0100, 'b1111,-1,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0000, 0, 'b0100, 'b0000, 'b0000, 'b1111, 2, 69, 80));
    // retrigger of held note 62 reuses voice 1 without a steal
    tbl.push_back(mk(0, 1, 1, 62, 50, 0, 'b0000, 1, 'b0010, 'b0000, 'b0000, 'b1111, 1, 62, 50));
    // velocity-0 ON acts as OFF; envelope_end frees releasing voice, ignored when held
    tbl.push_back(mk(1, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0000, 0,  0,  0));
    tbl.push_back(mk(0, 1, 1, 60,100, 0, 'b0000, 1, 'b0001, 'b0000, 'b0000, 'b0001, 0, 60,100));
    tbl.push_back(mk(0, 1, 1, 60,  0, 0, 'b0000, 1, 'b0000, 'b0001, 'b0000, 'b0001,-1,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0001, 1, 'b0000, 'b0000, 'b0000, 'b0000,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 61, 10, 0, 'b0000, 1, 'b0001, 'b0000, 'b0000, 'b0001, 0, 61, 10));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0001, 1, 'b0000, 'b0000, 'b0000, 'b0001,-1,  0,  0));
    // three held voices, then all-notes-off (the ON 70 offered alongside is refused)
    tbl.push_back(mk(0, 1, 1, 62, 20, 0, 'b0000, 1, 'b0010, 'b0000, 'b0000, 'b0011,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 63, 30, 0, 'b0000, 1, 'b0100, 'b0000, 'b0000, 'b0111,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 70, 40, 1, 'b0000, 0, 'b0000, 'b0111, 'b0000, 'b0111, 3,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0111,-1,  0,  0));
    // OFF for a releasing note: accepted, no effect
    tbl.push_back(mk(0, 1, 0, 62,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0111,-1,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0111, 1, 'b0000, 'b0000, 'b0000, 'b0000,-1,  0,  0));
    // reset in the middle of a steal: no voice_on, ready right after
    tbl.push_back(mk(0, 1, 1, 10,  1, 0, 'b0000, 1, 'b0001, 'b0000, 'b0000, 'b0001,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 11,  1, 0, 'b0000, 1, 'b0010, 'b0000, 'b0000, 'b0011,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 12,  1, 0, 'b0000, 1, 'b0100, 'b0000, 'b0000, 'b0111,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 13,  1, 0, 'b0000, 1, 'b1000, 'b0000, 'b0000, 'b1111,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 14,  1, 0, 'b0000, 1, 'b0000, 'b0000, 'b0001, 'b1111,-1,  0,  0));
    tbl.push_back(mk(1, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0000, 0,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0000,-1,  0,  0));
    // envelope_end coinciding with a retrigger of the same voice: allocation wins
    tbl.push_back(mk(0, 1, 1, 20,  5, 0, 'b0000, 1, 'b0001, 'b0000, 'b0000, 'b0001, 0, 20,  5));
    tbl.push_back(mk(0, 1, 0, 20,  0, 0, 'b0000, 1, 'b0000, 'b0001, 'b0000, 'b0001,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 20,  6, 0, 'b0001, 1, 'b0001, 'b0000, 'b0000, 'b0001, 0, 20,  6));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0001,-1,  0,  0));
    // all-notes-off during a steal waits for IDLE
    tbl.push_back(mk(0, 1, 1, 21,  7, 0, 'b0000, 1, 'b0010, 'b0000, 'b0000, 'b0011,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 22,  7, 0, 'b0000, 1, 'b0100, 'b0000, 'b0000, 'b0111,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 23,  7, 0, 'b0000, 1, 'b1000, 'b0000, 'b0000, 'b1111,-1,  0,  0));
    tbl.push_back(mk(0, 1, 1, 24, 33, 0, 'b0000, 1, 'b0000, 'b0000, 'b0001, 'b1111,-1,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 1, 'b0000, 0, 'b0001, 'b0000, 'b0000, 'b1111, 0, 24, 33));
    tbl.push_back(mk(0, 0, 0,  0,  0, 1, 'b0000, 0, 'b0000, 'b1111, 'b0000, 'b1111,-1,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b1111,-1,  0,  0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Hand-written: whole flattened note/velocity buses after two allocations.
    apply(mk(1, 0, 0, 0, 0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0000, -1, 0, 0), "bus rst");
    apply(mk(0, 1, 1, 5, 1, 0, 'b0000, 1, 'b0001, 'b0000, 'b0000, 'b0001, -1, 0, 0), "bus on5");
    apply(mk(0, 1, 1, 6, 2, 0, 'b0000, 1, 'b0010, 'b0000, 'b0000, 'b0011, -1, 0, 0), "bus on6");
    exp_notes = '0;
    exp_notes[NW-1:0]    = NW'(5);
    exp_notes[2*NW-1:NW] = NW'(6);
    exp_vels = '0;
    exp_vels[VW-1:0]     = VW'(1);
    exp_vels[2*VW-1:VW]  = VW'(2);
    chk("bus voice_note", 64'(voice_note), 64'(exp_notes));
    chk("bus voice_velocity", 64'(voice_velocity), 64'(exp_vels));

`ifdef SUSTAIN_PEDAL_EN
    // Hand-written: pedal holds a released note until the pedal is lifted.
    sustain = 1'b1;
    apply(mk(1, 0, 0,  0,   0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0000, -1, 0, 0), "sus rst");
    apply(mk(0, 1, 1, 60, 100, 0, 'b0000, 1, 'b0001, 'b0000, 'b0000, 'b0001, 0, 60, 100), "sus on");
    apply(mk(0, 1, 0, 60,   0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0001, -1, 0, 0), "sus off");
    apply(mk(0, 1, 1, 60,  70, 0, 'b0000, 1, 'b0001, 'b0000, 'b0000, 'b0001, 0, 60, 70), "sus retrig");
    apply(mk(0, 1, 0, 60,   0, 0, 'b0000, 1, 'b0000, 'b0000, 'b0000, 'b0001, -1, 0, 0), "sus off2");
    sustain = 1'b0;
    apply(mk(0, 0, 0,  0,   0, 0, 'b0000, 1, 'b0000, 'b0001, 'b0000, 'b0001, -1, 0, 0), "sus lift");
    apply(mk(0, 0, 0,  0,   0, 0, 'b0001, 1, 'b0000, 'b0000, 'b0000, 'b0000, -1, 0, 0), "sus end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
